// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the Zicsr execute-stage sequencer.
package csr_inc;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_mode_t;

  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam logic [11:0] CSR_ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_ADDR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_ADDR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } csr_acc_state_t;

  // RS/RC with x0 or uimm=0 are pure reads and must not touch the CSR.
  function automatic logic csr_do_write(input logic [2:0] funct3, input logic [4:0] rs1_idx);
    return (funct3[1:0] == CSR_OP_RW) || (rs1_idx != '0);
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request, CSR-file and response signals of the CSR access unit.
interface csr_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr_addr;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_value;
  logic [4:0]      req_rd;

  logic [11:0]     csr_addr;
  logic            csr_read_en;
  logic [XLEN-1:0] csr_read_data;
  logic            csr_read_illegal;
  logic            csr_write_en;
  logic [XLEN-1:0] csr_write_data;

  logic            resp_valid;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            illegal_instr_exception;

  // master: pipeline plus CSR file surrounding the unit; slave: the unit itself
  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_value, req_rd,
    output csr_read_data, csr_read_illegal,
    input  req_ready, csr_addr, csr_read_en, csr_write_en, csr_write_data,
    input  resp_valid, resp_rd, resp_data, illegal_instr_exception
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_value, req_rd,
    input  csr_read_data, csr_read_illegal,
    output req_ready, csr_addr, csr_read_en, csr_write_en, csr_write_data,
    output resp_valid, resp_rd, resp_data, illegal_instr_exception
  );
endinterface

// File: rtl/csr_access_unit_rmw_alu.sv
// Read-modify-write value for CSRRW/RS/RC and their immediate forms.
module csr_rmw_alu
  import csr_inc::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] old_value,
  output logic [XLEN-1:0] new_value,
  output logic            do_write
);
  logic [XLEN-1:0] src;

  always_comb begin
    src       = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_value;
    new_value = old_value;
    unique case (funct3[1:0])
      CSR_OP_RW: new_value = src;
      CSR_OP_RS: new_value = old_value | src;
      CSR_OP_RC: new_value = old_value & ~src;
      default:   new_value = old_value;
    endcase
    do_write = csr_do_write(funct3, rs1_idx);
  end
endmodule

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: pre-check, CSR read, optional write, single-cycle response.
module csr_access_unit
  import csr_inc::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input logic                clock,
  input logic                reset,
  input priv_mode_t          priv_mode,
  csr_access_unit_if.slave   bus
);
  csr_acc_state_t  state;
  logic [2:0]      funct3_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] rs1_value_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_value;
  logic            do_write;
  logic            pre_illegal;

  always_comb begin
    pre_illegal = (bus.req_funct3[1:0] == 2'b00)
               || (bus.req_csr_addr[9:8] > 2'(priv_mode))
               || (RO_CHECK && csr_do_write(bus.req_funct3, bus.req_rs1_idx)
                   && (bus.req_csr_addr[11:10] == 2'b11));
  end

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .funct3    (funct3_q),
    .rs1_idx   (rs1_idx_q),
    .rs1_value (rs1_value_q),
    .old_value (bus.csr_read_data),
    .new_value (new_value),
    .do_write  (do_write)
  );

  // Outputs are registered: each is set on the edge entering its state and cleared on exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                       <= IDLE;
      funct3_q                    <= '0;
      rs1_idx_q                   <= '0;
      rs1_value_q                 <= '0;
      rd_q                        <= '0;
      old_q                       <= '0;
      bus.req_ready               <= 1'b1;
      bus.csr_addr                <= '0;
      bus.csr_read_en             <= 1'b0;
      bus.csr_write_en            <= 1'b0;
      bus.csr_write_data          <= '0;
      bus.resp_valid              <= 1'b0;
      bus.resp_rd                 <= '0;
      bus.resp_data               <= '0;
      bus.illegal_instr_exception <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q      <= bus.req_funct3;
            rs1_idx_q     <= bus.req_rs1_idx;
            rs1_value_q   <= bus.req_rs1_value;
            rd_q          <= bus.req_rd;
            bus.csr_addr  <= bus.req_csr_addr;
            bus.req_ready <= 1'b0;
            if (pre_illegal) begin
              state                       <= RESP;
              bus.resp_valid              <= 1'b1;
              bus.illegal_instr_exception <= 1'b1;
            end else begin
              state           <= READ;
              bus.csr_read_en <= 1'b1;
            end
          end
        end
        READ: begin
          bus.csr_read_en <= 1'b0;
          old_q           <= bus.csr_read_data;
          if (bus.csr_read_illegal) begin
            state                       <= RESP;
            bus.resp_valid              <= 1'b1;
            bus.illegal_instr_exception <= 1'b1;
          end else if (do_write) begin
            state              <= WRITE;
            bus.csr_write_en   <= 1'b1;
            bus.csr_write_data <= new_value;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rd    <= rd_q;
            bus.resp_data  <= bus.csr_read_data;
          end
        end
        WRITE: begin
          state              <= RESP;
          bus.csr_write_en   <= 1'b0;
          bus.csr_write_data <= '0;
          bus.resp_valid     <= 1'b1;
          bus.resp_rd        <= rd_q;
          bus.resp_data      <= old_q;
        end
        RESP: begin
          state                       <= IDLE;
          bus.req_ready               <= 1'b1;
          bus.resp_valid              <= 1'b0;
          bus.resp_rd                 <= '0;
          bus.resp_data               <= '0;
          bus.illegal_instr_exception <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a response scoreboard.
module tb_csr_access_unit;
  import csr_inc::*;

  localparam int unsigned XLEN = 32;

  logic       clock = 1'b0;
  logic       reset;
  priv_mode_t priv_mode;

  always #5 clock = ~clock;

  csr_access_unit_if #(.XLEN(XLEN)) bus ();

  csr_access_unit #(.XLEN(XLEN), .RO_CHECK(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .priv_mode (priv_mode),
    .bus       (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // CSR file model: either a fixed value or a free-running counter like mcycle
  logic [31:0] rdata;
  bit          cnt_mode;
  logic        rill;
  assign bus.csr_read_data    = cnt_mode ? (32'h1000_0000 + cyc) : rdata;
  assign bus.csr_read_illegal = rill;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          chk("resp_rd", 32'(bus.resp_rd), 32'(e_mon.rd));
          chk("resp_data", bus.resp_data, e_mon.data);
          chk("resp_exc", 32'(bus.illegal_instr_exception), 32'(e_mon.exc));
          chk("resp_cycle", cyc, e_mon.due);
        end
      end else begin
        chk("resp_idle_zero",
            {bus.illegal_instr_exception, |bus.resp_rd, |bus.resp_data}, 32'd0);
      end
    end
  end

  task automatic run_op(
    input logic [2:0]  f3,
    input logic [11:0] addr,
    input logic [4:0]  idx,
    input logic [31:0] val,
    input logic [4:0]  rd,
    input priv_mode_t  pm,
    input logic [31:0] rd_val,
    input bit          cm,
    input bit          ill,
    input int unsigned lat,
    input bit          wr,
    input logic [31:0] wdata,
    input bit          exc,
    input bit          hold
  );
    int unsigned n;
    logic [31:0] old;
    exp_t e;
    @(negedge clock);
    chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
    rdata             = rd_val;
    cnt_mode          = cm;
    rill              = ill;
    priv_mode         = pm;
    bus.req_valid     = 1'b1;
    bus.req_funct3    = f3;
    bus.req_csr_addr  = addr;
    bus.req_rs1_idx   = idx;
    bus.req_rs1_value = val;
    bus.req_rd        = rd;
    n   = cyc;
    old = cm ? (32'h1000_0000 + n + 1) : rd_val;
    e.rd   = exc ? 5'd0 : rd;
    e.data = exc ? 32'd0 : old;
    e.exc  = exc;
    e.due  = n + lat;
    sb.push_back(e);
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clock);
      if (!hold) bus.req_valid = 1'b0;
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      chk("csr_read_en", 32'(bus.csr_read_en), 32'(lat > 1 && c == 1));
      chk("csr_write_en", 32'(bus.csr_write_en), 32'(wr && c == 2));
      chk("csr_write_data", bus.csr_write_data, (wr && c == 2) ? wdata : 32'd0);
      if (c == 1) chk("csr_addr", 32'(bus.csr_addr), 32'(addr));
    end
  endtask

  initial begin
    reset             = 1'b1;
    priv_mode         = PRIV_M;
    rdata             = '0;
    cnt_mode          = 1'b0;
    rill              = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_funct3    = '0;
    bus.req_csr_addr  = '0;
    bus.req_rs1_idx   = '0;
    bus.req_rs1_value = '0;
    bus.req_rd        = '0;
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_strobes", {bus.csr_read_en, bus.csr_write_en, bus.resp_valid,
                        bus.illegal_instr_exception}, 32'd0);
    chk("rst_csr_addr", 32'(bus.csr_addr), 32'd0);
    chk("rst_wdata", bus.csr_write_data, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // f3  addr  idx  val  rd  priv  rdata  cnt ill lat wr wdata exc hold
    run_op(3'b010, 12'hC00, 5'd0,  32'h0,        5'd5,  PRIV_U, 32'h0,        1, 0, 2, 0, 32'h0,        0, 0);
    run_op(3'b001, 12'h340, 5'd7,  32'hDEADBEEF, 5'd10, PRIV_M, 32'h12345678, 0, 0, 3, 1, 32'hDEADBEEF, 0, 0);
    run_op(3'b111, 12'h340, 5'h05, 32'hFFFFFFFF, 5'd3,  PRIV_M, 32'h0000000F, 0, 0, 3, 1, 32'h0000000A, 0, 0);
    run_op(3'b110, 12'h340, 5'h10, 32'h0,        5'd4,  PRIV_M, 32'h00000001, 0, 0, 3, 1, 32'h00000011, 0, 0);
    run_op(3'b001, 12'hC01, 5'd1,  32'h5,        5'd9,  PRIV_M, 32'h0,        0, 0, 1, 0, 32'h0,        1, 0);
    run_op(3'b001, 12'h300, 5'd1,  32'h5,        5'd9,  PRIV_U, 32'h0,        0, 0, 1, 0, 32'h0,        1, 0);
    run_op(3'b000, 12'h340, 5'd1,  32'h5,        5'd8,  PRIV_M, 32'h0,        0, 0, 1, 0, 32'h0,        1, 0);
    run_op(3'b110, 12'hC00, 5'd3,  32'h0,        5'd8,  PRIV_M, 32'h0,        0, 0, 1, 0, 32'h0,        1, 0);
    run_op(3'b011, 12'hC00, 5'd0,  32'hFFFF,     5'd6,  PRIV_U, 32'hA5A5A5A5, 0, 0, 2, 0, 32'h0,        0, 0);
    run_op(3'b010, 12'h100, 5'd2,  32'h0000F000, 5'd11, PRIV_S, 32'h00000F00, 0, 0, 3, 1, 32'h0000FF00, 0, 0);
    run_op(3'b010, 12'h200, 5'd2,  32'h1,        5'd11, PRIV_S, 32'h0,        0, 0, 1, 0, 32'h0,        1, 0);
    run_op(3'b001, 12'h340, 5'd1,  32'h0BADF00D, 5'd0,  PRIV_M, 32'h77777777, 0, 0, 3, 1, 32'h0BADF00D, 0, 0);
    // held request: second issue must be accepted the cycle after the exception pulse
    run_op(3'b001, 12'h7FF, 5'd1,  32'h1,        5'd12, PRIV_M, 32'h0,        0, 1, 2, 0, 32'h0,        1, 1);
    run_op(3'b001, 12'h7FF, 5'd1,  32'h1,        5'd12, PRIV_M, 32'h0,        0, 1, 2, 0, 32'h0,        1, 0);

    // reset while in READ: the pending write must never appear
    @(negedge clock);
    rill              = 1'b0;
    cnt_mode          = 1'b0;
    rdata             = 32'h11112222;
    priv_mode         = PRIV_M;
    bus.req_valid     = 1'b1;
    bus.req_funct3    = 3'b001;
    bus.req_csr_addr  = 12'h340;
    bus.req_rs1_idx   = 5'd7;
    bus.req_rs1_value = 32'hCAFEF00D;
    bus.req_rd        = 5'd13;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("rst_mid_read_en", 32'(bus.csr_read_en), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_strobes", {bus.csr_read_en, bus.csr_write_en, bus.resp_valid}, 32'd0);
    chk("rst_mid_addr", 32'(bus.csr_addr), 32'd0);
    chk("rst_mid_wdata", bus.csr_write_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_mid_no_write", 32'(bus.csr_write_en), 32'd0);
    end

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end
endmodule
